// File: rtl/fixed_lat_rr_sched.sv
// fixed_lat_rr_sched: round-robin scheduler sharing one fixed-latency,
// non-stallable pipeline among NumReq requesters.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_valid_i     per-requester request valid
//   req_ready_o     one-hot grant (combinational)
//   req_data_i      per-requester payload, slice r belongs to requester r
//   pipe_valid_o    issue valid into the shared pipeline (same cycle as grant)
//   pipe_data_o     issue payload (zero when nothing is issued)
//   pipe_valid_i    result valid, exactly Depth cycles after issue
//   pipe_data_i     result payload
//   resp_valid_o    response buffer r non-empty
//   resp_ready_i    requester r pops its response
//   resp_data_o     head of response buffer r
//   busy_o          registered: a result is in flight or buffered
//
// Each requester owns Credits response-buffer slots. A grant spends a credit
// and a pop returns it, so a returning result always finds a free slot even
// though the pipeline cannot be stalled.
module fixed_lat_rr_sched #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Credits   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic                          pipe_valid_o,
  output logic [DataWidth-1:0]          pipe_data_o,
  input  logic                          pipe_valid_i,
  input  logic [DataWidth-1:0]          pipe_data_i,
  output logic [NumReq-1:0]             resp_valid_o,
  input  logic [NumReq-1:0]             resp_ready_i,
  output logic [NumReq*DataWidth-1:0]   resp_data_o,
  output logic                          busy_o
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(Credits + 1);
  localparam int unsigned PtrW = (Credits > 1) ? $clog2(Credits) : 1;

  if (Depth < 1) begin : g_depth_chk
    $error("fixed_lat_rr_sched: Depth must be at least 1");
  end
  if (NumReq < 2) begin : g_numreq_chk
    $error("fixed_lat_rr_sched: NumReq must be at least 2");
  end
  if (Credits < 1) begin : g_credits_chk
    $error("fixed_lat_rr_sched: Credits must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]      credit_q [NumReq];
  logic [CntW-1:0]      credit_d [NumReq];
  logic [Depth-1:0]     id_vld_q, id_vld_d;
  logic [IdW-1:0]       id_q [Depth];
  logic [DataWidth-1:0] mem_q [NumReq][Credits];
  logic [PtrW-1:0]      wr_q [NumReq];
  logic [PtrW-1:0]      rd_q [NumReq];
  logic [CntW-1:0]      cnt_q [NumReq];
  logic [CntW-1:0]      cnt_d [NumReq];
  logic                 busy_q, busy_d;

  logic [DataWidth-1:0] req_data [NumReq];
  logic [NumReq-1:0]    eligible;
  logic [NumReq-1:0]    grant;
  logic                 issue;
  logic [IdW-1:0]       winner;
  logic                 ret_vld;
  logic [IdW-1:0]       ret_id;
  logic [NumReq-1:0]    push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Credits - 1) ? '0 : p + 1'b1;
  endfunction

  for (genvar g = 0; g < NumReq; g++) begin : g_req
    assign req_data[g]                              = req_data_i[g*DataWidth +: DataWidth];
    assign eligible[g]                              = req_valid_i[g] && (credit_q[g] != '0);
    assign resp_valid_o[g]                          = (cnt_q[g] != '0);
    assign resp_data_o[g*DataWidth +: DataWidth]    = mem_q[g][rd_q[g]];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: first eligible index at or after the pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    idx    = 0;
    grant  = '0;
    issue  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(rr_ptr_q) + i) % NumReq;
      if (!issue && eligible[IdW'(idx)]) begin
        issue  = 1'b1;
        winner = IdW'(idx);
      end
    end
    if (issue) begin
      grant[winner] = 1'b1;
    end
  end

  assign req_ready_o  = grant;
  assign pipe_valid_o = issue;
  assign pipe_data_o  = issue ? req_data[winner] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (32'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ID delay line: last stage lines up with pipe_valid_i.
  // ---------------------------------------------------------------------------
  always_comb begin
    id_vld_d    = '0;
    id_vld_d[0] = issue;
    for (int d = 1; d < Depth; d++) begin
      id_vld_d[d] = id_vld_q[d-1];
    end
  end

  assign ret_vld = id_vld_q[Depth-1];
  assign ret_id  = id_q[Depth-1];

  // ---------------------------------------------------------------------------
  // Buffer occupancy and credits
  // ---------------------------------------------------------------------------
  always_comb begin
    logic any_buf;
    any_buf = 1'b0;
    push    = '0;
    pop     = '0;
    for (int r = 0; r < NumReq; r++) begin
      // Untracked results (e.g. right after reset) are dropped.
      push[r]     = pipe_valid_i && ret_vld && (ret_id == IdW'(r));
      pop[r]      = resp_valid_o[r] && resp_ready_i[r];
      cnt_d[r]    = cnt_q[r] + CntW'(push[r]) - CntW'(pop[r]);
      credit_d[r] = credit_q[r] - CntW'(grant[r]) + CntW'(pop[r]);
      any_buf     = any_buf | (cnt_d[r] != '0);
    end
    busy_d = any_buf | (|id_vld_d);
  end

  assign busy_o = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      id_vld_q <= '0;
      for (int d = 0; d < Depth; d++) begin
        id_q[d] <= '0;
      end
      for (int r = 0; r < NumReq; r++) begin
        credit_q[r] <= CntW'(Credits);
        cnt_q[r]    <= '0;
        wr_q[r]     <= '0;
        rd_q[r]     <= '0;
        for (int e = 0; e < Credits; e++) begin
          mem_q[r][e] <= '0;
        end
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      id_vld_q <= id_vld_d;
      if (issue) begin
        id_q[0] <= winner;
      end
      // ID stages only load behind a valid stage, keeping idle toggling low.
      for (int d = 1; d < Depth; d++) begin
        if (id_vld_q[d-1]) begin
          id_q[d] <= id_q[d-1];
        end
      end
      for (int r = 0; r < NumReq; r++) begin
        credit_q[r] <= credit_d[r];
        cnt_q[r]    <= cnt_d[r];
        if (push[r]) begin
          mem_q[r][wr_q[r]] <= pipe_data_i;
          wr_q[r]           <= ptr_inc(wr_q[r]);
        end
        if (pop[r]) begin
          rd_q[r] <= ptr_inc(rd_q[r]);
        end
      end
    end
  end

`ifndef SYNTHESIS
  function automatic int unsigned inflight(input int r);
    int unsigned n;
    n = 0;
    for (int d = 0; d < Depth; d++) begin
      if (id_vld_q[d] && (id_q[d] == IdW'(r))) begin
        n++;
      end
    end
    return n;
  endfunction

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (pipe_valid_i == ret_vld)
        else $error("fixed_lat_rr_sched: pipe_valid_i disagrees with tracked issue");
      for (int r = 0; r < NumReq; r++) begin
        assert (32'(credit_q[r]) <= Credits)
          else $error("fixed_lat_rr_sched: credit %0d above limit", r);
        assert (32'(credit_q[r]) + inflight(r) + 32'(cnt_q[r]) == Credits)
          else $error("fixed_lat_rr_sched: credit invariant broken for %0d", r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fixed_lat_rr_sched.sv
// Directed, table-driven bench for fixed_lat_rr_sched with an identity
// Depth-stage pipeline model standing in for the shared pipeline.
module tb_fixed_lat_rr_sched;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned Depth     = 8;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned Credits   = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b1;
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*DataWidth-1:0] req_data_i;
  logic                        pipe_valid_o;
  logic [DataWidth-1:0]        pipe_data_o;
  logic                        pipe_valid_i;
  logic [DataWidth-1:0]        pipe_data_i;
  logic [NumReq-1:0]           resp_valid_o;
  logic [NumReq-1:0]           resp_ready_i;
  logic [NumReq*DataWidth-1:0] resp_data_o;
  logic                        busy_o;

  always #5 clk_i = ~clk_i;

  fixed_lat_rr_sched #(
    .NumReq    (NumReq),
    .Depth     (Depth),
    .DataWidth (DataWidth),
    .Credits   (Credits)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .pipe_valid_o (pipe_valid_o),
    .pipe_data_o  (pipe_data_o),
    .pipe_valid_i (pipe_valid_i),
    .pipe_data_i  (pipe_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .busy_o       (busy_o)
  );

  // Shared pipeline stand-in: pure delay of Depth cycles.
  logic [Depth-1:0]     pv_vld;
  logic [DataWidth-1:0] pv_data [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_vld <= '0;
      for (int d = 0; d < Depth; d++) pv_data[d] <= '0;
    end else begin
      pv_vld[0]  <= pipe_valid_o;
      pv_data[0] <= pipe_data_o;
      for (int d = 1; d < Depth; d++) begin
        pv_vld[d]  <= pv_vld[d-1];
        pv_data[d] <= pv_data[d-1];
      end
    end
  end

  assign pipe_valid_i = pv_vld[Depth-1];
  assign pipe_data_i  = pv_data[Depth-1];

  logic [DataWidth-1:0] payload [NumReq];
  logic [DataWidth-1:0] expq [NumReq][$];

  for (genvar g = 0; g < NumReq; g++) begin : g_pay
    assign req_data_i[g*DataWidth +: DataWidth] = payload[g];
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reset asynchronously, check reset outputs, release away from the edge.
  task automatic do_reset();
    req_valid_i  = '0;
    resp_ready_i = '0;
    rst_ni       = 1'b0;
    #3;
    check("rst req_ready", 32'(req_ready_o), 32'd0);
    check("rst pipe_valid", 32'(pipe_valid_o), 32'd0);
    check("rst pipe_data", pipe_data_o, 32'd0);
    check("rst resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst resp_data0", resp_data_o[0 +: DataWidth], 32'd0);
    for (int r = 0; r < NumReq; r++) expq[r].delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // One clock cycle: drive, compare on the falling edge, then advance.
  task automatic cycle(input logic [NumReq-1:0] v, input logic [NumReq-1:0] rr,
                       input logic [NumReq-1:0] exp_rdy, input logic [NumReq-1:0] exp_rv,
                       input string tag);
    logic [DataWidth-1:0] exp_data;
    req_valid_i  = v;
    resp_ready_i = rr;
    @(negedge clk_i);
    exp_data = '0;
    for (int r = 0; r < NumReq; r++) if (exp_rdy[r]) exp_data = payload[r];
    check({tag, " req_ready"}, 32'(req_ready_o), 32'(exp_rdy));
    check({tag, " pipe_valid"}, 32'(pipe_valid_o), 32'(|exp_rdy));
    check({tag, " pipe_data"}, pipe_data_o, exp_data);
    check({tag, " resp_valid"}, 32'(resp_valid_o), 32'(exp_rv));
    for (int r = 0; r < NumReq; r++) begin
      if (exp_rv[r]) begin
        if (expq[r].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s resp_data[%0d]: got 0x%0h, expected nothing buffered", tag, r,
                   resp_data_o[r*DataWidth +: DataWidth]);
        end else begin
          check($sformatf("%s resp_data[%0d]", tag, r),
                resp_data_o[r*DataWidth +: DataWidth], expq[r][0]);
          if (rr[r]) void'(expq[r].pop_front());
        end
      end
    end
    @(posedge clk_i);
    #1;
    for (int r = 0; r < NumReq; r++) begin
      if (exp_rdy[r]) begin
        expq[r].push_back(payload[r]);
        payload[r] = payload[r] + 32'd1;
      end
    end
  endtask

  typedef struct {
    logic              do_rst;
    logic [NumReq-1:0] valid;
    logic [NumReq-1:0] rready;
    logic [NumReq-1:0] exp_ready;
    logic [NumReq-1:0] exp_rvalid;
  } vec_t;

  vec_t tbl [$];

  initial begin
    req_valid_i  = '0;
    resp_ready_i = '0;
    for (int r = 0; r < NumReq; r++) payload[r] = (32'(r) << 8) | 32'hA0;
    #2;

    // Full load with immediate pops: order 0,1,2,3 then credit-limited gaps.
    // A credit comes back Depth+2 cycles after its grant.
    tbl.push_back('{1'b1, 4'b0000, 4'hF, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b0001, 4'hF, 4'b0001, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0010, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0100, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b1000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0001, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0010, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0100, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b1000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0001, 4'b0010});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0010, 4'b0100});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0100, 4'b1000});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b1000, 4'b0001});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0001, 4'b0010});
    tbl.push_back('{1'b0, 4'b1111, 4'hF, 4'b0010, 4'b0100});
    // Requester 0 out of credit is skipped; pointer keeps moving past 2.
    tbl.push_back('{1'b1, 4'b0001, 4'h0, 4'b0001, 4'b0000});
    tbl.push_back('{1'b0, 4'b0001, 4'h0, 4'b0001, 4'b0000});
    tbl.push_back('{1'b0, 4'b0101, 4'h0, 4'b0100, 4'b0000});
    tbl.push_back('{1'b0, 4'b0101, 4'h0, 4'b0100, 4'b0000});
    tbl.push_back('{1'b0, 4'b0101, 4'h0, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1010, 4'h0, 4'b1000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1010, 4'h0, 4'b0010, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      cycle(tbl[i].valid, tbl[i].rready, tbl[i].exp_ready, tbl[i].exp_rvalid,
            $sformatf("vec%0d", i));
    end

    // Requester 1 alone, no pops: two grants, buffer fills in issue order.
    do_reset();
    cycle(4'b0010, 4'b0000, 4'b0010, 4'b0000, "solo c0");
    check("solo busy", 32'(busy_o), 32'd1);
    cycle(4'b0010, 4'b0000, 4'b0010, 4'b0000, "solo c1");
    for (int i = 2; i < 12; i++) begin
      cycle(4'b0010, 4'b0000, 4'b0000, (i >= 9) ? 4'b0010 : 4'b0000,
            $sformatf("solo c%0d", i));
    end
    cycle(4'b0010, 4'b0010, 4'b0000, 4'b0010, "solo pop");
    cycle(4'b0010, 4'b0000, 4'b0010, 4'b0010, "solo regrant");
    cycle(4'b0000, 4'b0000, 4'b0000, 4'b0010, "solo hold");

    // Requester 3: pop at credit 0 with a full buffer, then pop+grant together.
    do_reset();
    cycle(4'b1000, 4'b0000, 4'b1000, 4'b0000, "r3 c0");
    cycle(4'b1000, 4'b0000, 4'b1000, 4'b0000, "r3 c1");
    for (int i = 2; i < 11; i++) begin
      cycle(4'b1000, 4'b0000, 4'b0000, (i >= 9) ? 4'b1000 : 4'b0000,
            $sformatf("r3 c%0d", i));
    end
    cycle(4'b1000, 4'b1000, 4'b0000, 4'b1000, "r3 pop at credit0");
    cycle(4'b1000, 4'b1000, 4'b1000, 4'b1000, "r3 pop+grant");
    cycle(4'b1000, 4'b1000, 4'b1000, 4'b0000, "r3 credit kept");
    cycle(4'b1000, 4'b1000, 4'b0000, 4'b0000, "r3 exhausted");

    // Reset with five results in flight discards them and restores credits.
    do_reset();
    cycle(4'b1111, 4'hF, 4'b0001, 4'b0000, "mid c0");
    cycle(4'b1111, 4'hF, 4'b0010, 4'b0000, "mid c1");
    cycle(4'b1111, 4'hF, 4'b0100, 4'b0000, "mid c2");
    cycle(4'b1111, 4'hF, 4'b1000, 4'b0000, "mid c3");
    cycle(4'b1111, 4'hF, 4'b0001, 4'b0000, "mid c4");
    check("mid busy before reset", 32'(busy_o), 32'd1);
    do_reset();
    check("mid busy after reset", 32'(busy_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0000, 4'hF, 4'b0000, 4'b0000, $sformatf("mid drain%0d", i));
    end
    cycle(4'b0001, 4'h0, 4'b0001, 4'b0000, "mid credit a");
    cycle(4'b0001, 4'h0, 4'b0001, 4'b0000, "mid credit b");
    cycle(4'b0001, 4'h0, 4'b0000, 4'b0000, "mid credit c");
    check("mid busy refill", 32'(busy_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
